// File: rtl/ofdm_preamble_insert.sv
// OFDM transmit framer: one constant training symbol, then data symbols.
// Optional guard gap after the preamble: define OFDM_PREAMBLE_GUARD_EN.
module ofdm_preamble_insert #(
  parameter int DATA_SIZE    = 16,
  parameter int FFT_SIZE     = 256,
  parameter int DATA_SYMBOLS = 4,
  parameter int PREAMBLE_I   = 7680,
  parameter int PREAMBLE_Q   = 7680,
  parameter int GUARD_LEN    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_data_i,
  input  logic [DATA_SIZE-1:0] i_data_q,
  input  logic                 i_valid,
  output logic                 o_wayt_data,
  input  logic                 i_sync_frame,
  output logic [DATA_SIZE-1:0] o_data_i,
  output logic [DATA_SIZE-1:0] o_data_q,
  output logic                 o_valid,
  output logic                 o_preamble,
  output logic                 o_frame_start,
  input  logic                 i_wayt_data
);

  localparam int PW = $clog2(FFT_SIZE);
  localparam int DW = $clog2(DATA_SYMBOLS * FFT_SIZE);

  localparam logic [PW-1:0] P_LAST = PW'(FFT_SIZE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DATA_SYMBOLS * FFT_SIZE - 1);

  localparam logic [DATA_SIZE-1:0] PRE_I = DATA_SIZE'(PREAMBLE_I);
  localparam logic [DATA_SIZE-1:0] PRE_Q = DATA_SIZE'(PREAMBLE_Q);

`ifdef OFDM_PREAMBLE_GUARD_EN
  localparam int GW = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GUARD    = 2'd3
  } state_t;

  logic [GW-1:0] gcnt;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;
`endif

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] dcnt;

  logic free;
  logic in_xfer;

  assign free    = !o_valid || !i_wayt_data;
  assign in_xfer = i_valid && !o_wayt_data;

  // Upstream is only accepted in DATA, when the output register can take it.
  always_comb begin
    o_wayt_data = 1'b1;
    if (!i_sync_frame && state == DATA)
      o_wayt_data = o_valid && i_wayt_data;
  end

  // Frame sequencer and registered output stage.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= IDLE;
      pcnt          <= '0;
      dcnt          <= '0;
`ifdef OFDM_PREAMBLE_GUARD_EN
      gcnt          <= '0;
`endif
      o_valid       <= 1'b0;
      o_data_i      <= '0;
      o_data_q      <= '0;
      o_preamble    <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      if (free)
        o_valid <= 1'b0;

      if (i_sync_frame) begin
        state <= PREAMBLE;
        pcnt  <= '0;
        dcnt  <= '0;
`ifdef OFDM_PREAMBLE_GUARD_EN
        gcnt  <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (i_valid)
              state <= PREAMBLE;
          end

          PREAMBLE: begin
            if (free) begin
              o_valid       <= 1'b1;
              o_data_i      <= PRE_I;
              o_data_q      <= PRE_Q;
              o_preamble    <= 1'b1;
              o_frame_start <= (pcnt == '0);
              if (pcnt == P_LAST) begin
                pcnt  <= '0;
`ifdef OFDM_PREAMBLE_GUARD_EN
                state <= GUARD;
`else
                state <= DATA;
`endif
              end else begin
                pcnt <= pcnt + 1'b1;
              end
            end
          end

`ifdef OFDM_PREAMBLE_GUARD_EN
          GUARD: begin
            if (free) begin
              o_valid       <= 1'b1;
              o_data_i      <= '0;
              o_data_q      <= '0;
              o_preamble    <= 1'b0;
              o_frame_start <= 1'b0;
              if (gcnt == G_LAST) begin
                gcnt  <= '0;
                state <= DATA;
              end else begin
                gcnt <= gcnt + 1'b1;
              end
            end
          end
`endif

          DATA: begin
            if (in_xfer) begin
              o_valid       <= 1'b1;
              o_data_i      <= i_data_i;
              o_data_q      <= i_data_q;
              o_preamble    <= 1'b0;
              o_frame_start <= 1'b0;
              if (dcnt == D_LAST) begin
                dcnt  <= '0;
                state <= IDLE;
              end else begin
                dcnt <= dcnt + 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ofdm_preamble_insert.md
Name: ofdm_preamble_insert

Overview:
- Transmit-side framer that is the counterpart of the receive equalizer.
- On each frame, emits one known training symbol of FFT_SIZE constant samples (PREAMBLE_I/PREAMBLE_Q), then passes DATA_SYMBOLS*FFT_SIZE user samples through.
- Sits before the IFFT, so the far-end equalizer can estimate channel coefficients from the training symbol.
- Streaming interface on both sides, with valid/wait backpressure.

Parameters:
- DATA_SIZE, 16, width of each I and Q sample.
- FFT_SIZE, 256, samples per OFDM symbol (power of two).
- DATA_SYMBOLS, 4, data symbols per frame.
- PREAMBLE_I, 7680, I value of every training sample.
- PREAMBLE_Q, 7680, Q value of every training sample.
- GUARD_LEN, 16, zero samples inserted after the preamble (used only with the optional feature).

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_data_i  in  DATA_SIZE  input sample, I.
- i_data_q  in  DATA_SIZE  input sample, Q.
- i_valid  in  1  input sample present.
- o_wayt_data  out  1  upstream must hold its sample (combinational).
- i_sync_frame  in  1  one-cycle pulse: restart the frame at the preamble.
- o_data_i  out  DATA_SIZE  output sample, I (registered).
- o_data_q  out  DATA_SIZE  output sample, Q (registered).
- o_valid  out  1  output sample present.
- o_preamble  out  1  current output sample is a training sample.
- o_frame_start  out  1  high with the first preamble sample of a frame.
- i_wayt_data  in  1  downstream stall.

Behaviour:
- Handshakes:
  - Input transfer: i_valid && !o_wayt_data.
  - Output transfer: o_valid && !i_wayt_data.
  - Output register is "free" when !o_valid || !i_wayt_data.
- Reset (i_reset==0 at a clock edge), takes priority over everything:
  - state=IDLE, counters=0.
  - o_valid=0, o_data_i=0, o_data_q=0, o_preamble=0, o_frame_start=0.
  - The same applies mid-frame: any held sample is discarded.
- State IDLE:
  - o_wayt_data=1; no output loads.
  - i_valid=1 or i_sync_frame=1 -> PREAMBLE next cycle. The pending input sample is not consumed.
- State PREAMBLE:
  - o_wayt_data=1.
  - Each cycle the register is free: load PREAMBLE_I/Q, o_valid=1, o_preamble=1, pcnt++.
  - o_frame_start=1 only on the load with pcnt==0.
  - Load with pcnt==FFT_SIZE-1 -> DATA, pcnt=0.
- State DATA:
  - o_wayt_data = o_valid && i_wayt_data.
  - Each input transfer loads the register with the input sample, o_valid=1, o_preamble=0, dcnt++.
  - Transfer with dcnt==DATA_SYMBOLS*FFT_SIZE-1 -> IDLE, dcnt=0.
- Register drain: if the register is free and nothing loads, o_valid=0.
- Latency:
  - First preamble sample appears on o_valid 2 cycles after i_valid first rises in IDLE.
  - Data path is 1 cycle from input transfer to o_valid.
  - Full throughput (one sample per clock) when i_wayt_data=0.
- Stalls: while i_wayt_data=1 and o_valid=1, o_data_*, o_preamble and o_frame_start hold; counters freeze.
- i_sync_frame (any state except reset):
  - Forces PREAMBLE with pcnt=dcnt=0 on the next cycle.
  - o_wayt_data=1 in the pulse cycle, so no input is accepted that cycle.
  - The held output sample still completes its transfer normally.
- Counter widths: clog2(FFT_SIZE) for pcnt; clog2(DATA_SYMBOLS*FFT_SIZE) for dcnt. Both wrap only via the terminal-count transitions above.
- Data values pass bit-exact; no arithmetic on samples.

Optional Feature:
- Macro: OFDM_PREAMBLE_GUARD_EN.
- Defined:
  - Extra state GUARD between PREAMBLE and DATA.
  - Emits GUARD_LEN samples of 0/0 with o_preamble=0; o_wayt_data=1 throughout.
  - Last guard load -> DATA.
  - i_sync_frame and reset behave as in the other states.
- Undefined: no GUARD state; PREAMBLE goes directly to DATA; GUARD_LEN is unused.

Test Plan:
- Basic frame (defaults), i_valid=1 constant 5760/5760, i_wayt_data=0:
  - 256 outputs of 7680/7680 with o_preamble=1; o_frame_start only on the first.
  - Then 1024 outputs of 5760; then IDLE.
  - Next frame starts without gaps beyond the IDLE cycle.
- Backpressure: i_wayt_data toggles 1/0 every 3 cycles during PREAMBLE and DATA:
  - Output sequence is identical to the basic frame; no sample is duplicated or lost.
  - Data held stable while stalled.
- Upstream gaps: i_valid low 2 of every 5 cycles in DATA:
  - o_valid gaps follow the input gaps with 1-cycle latency.
  - Total data count is 1024.
- Mid-frame resync: i_sync_frame pulsed at dcnt==100:
  - The held sample drains.
  - Next 256 outputs are preamble with o_frame_start on the first.
  - dcnt restarts at 0.
- Reset mid-preamble: i_reset=0 for 1 cycle at pcnt==50:
  - Next cycle o_valid=0, outputs 0, state IDLE.
  - With i_valid still high, the preamble restarts at pcnt 0.
- With OFDM_PREAMBLE_GUARD_EN, GUARD_LEN=16: 256 preamble samples, then 16 zero samples (o_preamble=0), then 1024 data samples.
